// File: rtl/miriscv_lsu_pkg.sv
// Shared size encodings, FSM state type and request-side helpers for the LSU.
package miriscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } lsu_state_e;

   // Legal size with natural alignment; anything else is reported as an error.
   function automatic logic access_ok(input logic [2:0] size, input logic [1:0] off);
      case (size)
         LDST_B, LDST_BU: return 1'b1;
         LDST_H, LDST_HU: return ~off[0];
         LDST_W:          return (off == 2'b00);
         default:         return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
      case (size)
         LDST_B, LDST_BU: return 4'b0001 << off;
         LDST_H, LDST_HU: return 4'b0011 << {off[1], 1'b0};
         default:         return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_gen(input logic [2:0] size, input logic [31:0] data);
      case (size)
         LDST_B, LDST_BU: return {4{data[7:0]}};
         LDST_H, LDST_HU: return {2{data[15:0]}};
         default:         return data;
      endcase
   endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface miriscv_lsu_if;

   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i;

   modport master (
      output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      input  data_rdata_i
   );

   modport slave (
      input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
      output data_rdata_i
   );

endinterface

// File: rtl/miriscv_lsu_load_ext.sv
// Picks the addressed byte/half out of the memory word and sign- or zero-extends it.
module miriscv_lsu_load_ext
   import miriscv_lsu_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data = {24'd0, byte_sel};
         LDST_H:  data = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/miriscv_lsu.sv
// Two-state load/store unit: issues one data-memory access, then returns the
// extended load result in the following cycle.
module miriscv_lsu
   import miriscv_lsu_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          lsu_req_i,
   input  logic          lsu_we_i,
   input  logic [2:0]    lsu_size_i,
   input  logic [31:0]   lsu_addr_i,
   input  logic [31:0]   lsu_data_i,
   output logic [31:0]   lsu_data_o,
   output logic          lsu_stall_req_o,
   output logic          lsu_err_o,
   miriscv_lsu_if.master dmem
);

   lsu_state_e  state;
   logic [2:0]  size_p1;
   logic [1:0]  offset_p1;
   logic        ld_p1;
   logic        idle;
   logic        legal;
   logic        access;
   logic [31:0] ext_data;

   // Reset masks every output so nothing leaks while it is held.
   assign idle   = (state == ST_IDLE) & ~rst_i;
   assign legal  = access_ok(lsu_size_i, lsu_addr_i[1:0]);
   assign access = idle & lsu_req_i & legal;

   assign lsu_err_o       = idle & lsu_req_i & ~legal;
   assign lsu_stall_req_o = access;

   assign dmem.data_req_o   = access;
   assign dmem.data_we_o    = access & lsu_we_i;
   assign dmem.data_addr_o  = access ? lsu_addr_i : 32'd0;
   assign dmem.data_be_o    = access ? be_gen(lsu_size_i, lsu_addr_i[1:0]) : 4'd0;
   assign dmem.data_wdata_o = access ? wdata_gen(lsu_size_i, lsu_data_i) : 32'd0;

   // p0 -> p1: capture access shape for the response cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         size_p1   <= 3'd0;
         offset_p1 <= 2'd0;
         ld_p1     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access) begin
                  state     <= ST_WAIT;
                  size_p1   <= lsu_size_i;
                  offset_p1 <= lsu_addr_i[1:0];
                  ld_p1     <= ~lsu_we_i;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   miriscv_lsu_load_ext u_load_ext (
      .size   (size_p1),
      .offset (offset_p1),
      .rdata  (dmem.data_rdata_i),
      .data   (ext_data)
   );

   assign lsu_data_o = ((state == ST_WAIT) && ld_p1 && !rst_i) ? ext_data : 32'd0;

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port lsu_req_i, input, 1: core requests a memory access.
REQ-004 SHALL have port lsu_we_i, input, 1: 1 = store, 0 = load.
REQ-005 SHALL have port lsu_size_i, input, 3: access size per funct3; legal values 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 SHALL have port lsu_addr_i, input, 32: byte address.
REQ-007 SHALL have port lsu_data_i, input, 32: store data, right-aligned.
REQ-008 SHALL have port lsu_data_o, output, 32: extended load result.
REQ-009 SHALL have port lsu_stall_req_o, output, 1: core must hold its pipeline.
REQ-010 SHALL have port lsu_err_o, output, 1: misaligned access or illegal size.
REQ-011 SHALL have ports data_req_o (1), data_we_o (1), data_be_o (4), data_addr_o (32) and data_wdata_o (32), all outputs, forming the data-memory request.
REQ-012 SHALL have port data_rdata_i, input, 32: memory read word, valid the cycle after an accepted request.

Function
REQ-013 SHALL implement a two-state FSM: IDLE -> WAIT when lsu_req_i=1 and no error; WAIT -> IDLE unconditionally.
REQ-014 In IDLE with a legal request, SHALL drive data_req_o=1 and lsu_stall_req_o=1 combinationally in the same cycle.
REQ-015 In WAIT, SHALL drive data_req_o=0 and lsu_stall_req_o=0; lsu_req_i is ignored there. Throughput is one access per 2 cycles; load latency is 1 cycle.
REQ-016 SHALL drive data_addr_o = lsu_addr_i unmodified and data_we_o = lsu_we_i.
REQ-017 SHALL generate data_be_o as follows:
- B/BU: 4'b0001 << addr[1:0]
- H/HU: 4'b0011 << {addr[1],1'b0}
- W: 4'b1111
REQ-018 SHALL replicate store data on data_wdata_o: byte -> {4{data[7:0]}}; half -> {2{data[15:0]}}; word -> data unchanged.
REQ-019 SHALL register size and addr[1:0] on entry to WAIT.
REQ-020 In WAIT after a load, SHALL select the byte or half of data_rdata_i using the registered offset, then sign-extend (B, H) or zero-extend (BU, HU); lsu_data_o SHALL be 0 in all other cycles.
REQ-021 SHALL treat H/HU with addr[0]=1, W with addr[1:0]!=0, or an illegal size as an error:
- lsu_err_o=1 combinationally in that IDLE cycle
- data_req_o=0, lsu_stall_req_o=0
- state remains IDLE
REQ-022 lsu_err_o SHALL be 0 whenever lsu_req_i=0 or the state is WAIT.

Reset
REQ-023 While rst_i=1 at a clock edge, SHALL set the state to IDLE and clear the registered size and offset.
REQ-024 During and after reset, all outputs SHALL be 0 until a new request arrives.
REQ-025 Reset asserted in WAIT SHALL abandon the access; no lsu_data_o is produced for it.

Structure
REQ-026 SHALL take the size encodings (LDST_B/H/W/BU/HU) and the FSM state enum from shared package miriscv_lsu_pkg.
REQ-027 SHALL place load extraction and extension in one combinational sub-module, miriscv_lsu_load_ext.

Verification
REQ-028 Bench SHALL preload the word at 0x10 with 0x8081F2A3 and check:
- LB at 0x11 -> lsu_data_o=0xFFFFFFF2 in WAIT
- LBU at 0x11 -> 0x000000F2
REQ-029 Bench SHALL check:
- LH at 0x12 -> 0xFFFF8081
- LHU at 0x12 -> 0x00008081
- stall high for exactly 1 cycle each
REQ-030 Bench SHALL check SB at 0x13 with data 0x000000AB -> data_be_o=4'b1000, data_wdata_o=0xABABABAB; a following LW at 0x10 -> 0xAB81F2A3.
REQ-031 Bench SHALL check SH at 0x11 and LW at 0x12 -> lsu_err_o=1, data_req_o=0, stall 0, memory unchanged; size 011 -> lsu_err_o=1.
REQ-032 Bench SHALL check:
- back-to-back LW at 0x10 then SW at 0x14 -> second data_req_o exactly 2 cycles after the first
- rst_i asserted in WAIT -> next cycle IDLE, all outputs 0
